// File: rtl/seq_pkg.sv
// Shared definitions for the instruction sequencer: opcodes, FSM states and instruction field positions.
// The BEQ opcode is only treated as defined when the SEQ_BEQ_EN macro is set.
package seq_pkg;

    localparam int OP_MSB = 7;
    localparam int OP_LSB = 4;
    localparam int RD_MSB = 3;
    localparam int RD_LSB = 2;
    localparam int RS_MSB = 1;
    localparam int RS_LSB = 0;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4;
    localparam logic [3:0] OP_LD   = 4'h5;
    localparam logic [3:0] OP_ST   = 4'h6;
    localparam logic [3:0] OP_LDI  = 4'h7;
    localparam logic [3:0] OP_JMP  = 4'h8;
    localparam logic [3:0] OP_BEQ  = 4'h9;
    localparam logic [3:0] OP_HALT = 4'hF;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_IMM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6
    } seq_state_e;

    function automatic logic opDefined(input logic [3:0] op);
        logic ok;
        ok = (op <= OP_JMP) || (op == OP_HALT);
`ifdef SEQ_BEQ_EN
        ok = ok || (op == OP_BEQ);
`endif
        return ok;
    endfunction

endpackage

// File: rtl/seq_alu.sv
// Combinational ALU for the sequencer: ADD/SUB/AND/OR modulo 2^WIDTH plus an A==B compare for BEQ.
module seq_alu
    import seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] res,
    output logic             eq
);

    always_comb begin
        res = '0;
        unique case (op)
            OP_ADD:  res = a + b;
            OP_SUB:  res = a - b;
            OP_AND:  res = a & b;
            OP_OR:   res = a | b;
            default: res = '0;
        endcase
    end

    assign eq = (a == b);

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle fetch/decode/execute controller owning the pc and driving register bank and data memory.
// Optional feature: define SEQ_BEQ_EN to enable the BEQ (skip-next-if-equal) opcode.
module instr_sequencer
    import seq_pkg::*;
#(
    parameter int               WIDTH    = 8,
    parameter logic [WIDTH-1:0] PC_RESET = 8'h00
) (
    input  logic             ck,
    input  logic             rst,
    input  logic [WIDTH-1:0] instr,
    output logic [WIDTH-1:0] pc_out,
    output logic [1:0]       rf_s1,
    output logic [1:0]       rf_s2,
    input  logic [WIDTH-1:0] rf_rdata1,
    input  logic [WIDTH-1:0] rf_rdata2,
    output logic [1:0]       rf_d,
    output logic             rf_we,
    output logic [WIDTH-1:0] rf_wdata,
    output logic [WIDTH-1:0] dm_addr,
    output logic [WIDTH-1:0] dm_wdata,
    output logic             dm_we,
    output logic             dm_re,
    input  logic [WIDTH-1:0] dm_rdata,
    output logic             halted,
    output logic             illegal
);

    seq_state_e       state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] ir_q, ir_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             illegal_q, illegal_d;
    logic [WIDTH-1:0] aluRes;
    logic [3:0]       op;
`ifdef SEQ_BEQ_EN
    logic             aluEq;
`endif

    assign op = ir_q[OP_MSB:OP_LSB];

    seq_alu #(.WIDTH(WIDTH)) u_alu (
        .op  (op),
        .a   (a_q),
        .b   (b_q),
        .res (aluRes),
`ifdef SEQ_BEQ_EN
        .eq  (aluEq)
`else
        .eq  ()
`endif
    );

    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            state_q   <= ST_FETCH;
            pc_q      <= PC_RESET;
            ir_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            res_q     <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            a_q       <= a_d;
            b_q       <= b_d;
            res_q     <= res_d;
            illegal_q <= illegal_d;
        end
    end

    // Strobes are decoded from the state alone, so an async reset drops them immediately.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        a_d       = a_q;
        b_d       = b_q;
        res_d     = res_q;
        illegal_d = illegal_q;
        pc_out    = pc_q;
        rf_we     = 1'b0;
        dm_we     = 1'b0;
        dm_re     = 1'b0;

        unique case (state_q)
            ST_FETCH: begin
                ir_d    = instr;
                state_d = ST_DECODE;
            end
            ST_DECODE: begin
                a_d = rf_rdata1;
                b_d = rf_rdata2;
                if (!opDefined(op)) begin
                    illegal_d = 1'b1;
                    pc_d      = pc_q + WIDTH'(1);
                    state_d   = ST_FETCH;
                end else if (op == OP_NOP) begin
                    pc_d    = pc_q + WIDTH'(1);
                    state_d = ST_FETCH;
                end else if (op == OP_HALT) begin
                    state_d = ST_HALT;
                end else if (op == OP_LDI) begin
                    state_d = ST_IMM;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                res_d   = aluRes;
                state_d = ST_WB;
                if (op == OP_LD || op == OP_ST) begin
                    state_d = ST_MEM;
                end else if (op == OP_JMP) begin
                    pc_d    = b_q;
                    state_d = ST_FETCH;
                end
`ifdef SEQ_BEQ_EN
                else if (op == OP_BEQ) begin
                    pc_d    = aluEq ? pc_q + WIDTH'(2) : pc_q + WIDTH'(1);
                    state_d = ST_FETCH;
                end
`endif
            end
            ST_MEM: begin
                if (op == OP_LD) begin
                    dm_re   = 1'b1;
                    res_d   = dm_rdata;
                    state_d = ST_WB;
                end else begin
                    dm_we   = 1'b1;
                    pc_d    = pc_q + WIDTH'(1);
                    state_d = ST_FETCH;
                end
            end
            ST_IMM: begin
                pc_out  = pc_q + WIDTH'(1);
                res_d   = instr;
                state_d = ST_WB;
            end
            ST_WB: begin
                rf_we   = 1'b1;
                pc_d    = (op == OP_LDI) ? pc_q + WIDTH'(2) : pc_q + WIDTH'(1);
                state_d = ST_FETCH;
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    assign rf_s1    = ir_q[RD_MSB:RD_LSB];
    assign rf_s2    = ir_q[RS_MSB:RS_LSB];
    assign rf_d     = ir_q[RD_MSB:RD_LSB];
    assign rf_wdata = res_q;
    assign dm_addr  = b_q;
    assign dm_wdata = a_q;
    assign halted   = (state_q == ST_HALT);
    assign illegal  = illegal_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed self-checking bench for instr_sequencer with models of instruction memory, register bank and data memory.
// Expectations for opcode 9 follow the SEQ_BEQ_EN macro.
module tb_instr_sequencer;

    logic       ck = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] instr = 8'h00;
    logic [7:0] pc_out;
    logic [1:0] rf_s1, rf_s2, rf_d;
    logic [7:0] rf_rdata1, rf_rdata2, rf_wdata;
    logic       rf_we;
    logic [7:0] dm_addr, dm_wdata, dm_rdata;
    logic       dm_we, dm_re;
    logic       halted, illegal;

    logic [7:0] imem [256];
    logic [7:0] regs [4];
    logic [7:0] dmem [256];

    logic       loadReg = 1'b0;
    logic       loadMem = 1'b0;
    logic [7:0] loadAddr = 8'h00;
    logic [7:0] loadVal = 8'h00;

    int checks = 0;
    int failures = 0;

    always #5 ck = ~ck;

    instr_sequencer #(.WIDTH(8), .PC_RESET(8'h00)) dut (
        .ck        (ck),
        .rst       (rst),
        .instr     (instr),
        .pc_out    (pc_out),
        .rf_s1     (rf_s1),
        .rf_s2     (rf_s2),
        .rf_rdata1 (rf_rdata1),
        .rf_rdata2 (rf_rdata2),
        .rf_d      (rf_d),
        .rf_we     (rf_we),
        .rf_wdata  (rf_wdata),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_we     (dm_we),
        .dm_re     (dm_re),
        .dm_rdata  (dm_rdata),
        .halted    (halted),
        .illegal   (illegal)
    );

    // Instruction memory registers its output on the falling edge.
    always @(negedge ck) instr <= imem[pc_out];

    assign rf_rdata1 = regs[rf_s1];
    assign rf_rdata2 = regs[rf_s2];
    assign dm_rdata  = dmem[dm_addr];

    always @(posedge ck) begin
        if (loadReg) regs[loadAddr[1:0]] <= loadVal;
        if (loadMem) dmem[loadAddr] <= loadVal;
        if (rf_we && rf_d != 2'd3) regs[rf_d] <= rf_wdata;
        if (dm_we) dmem[dm_addr] <= dm_wdata;
    end

    task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic setReg(input int idx, input logic [7:0] val);
        loadAddr = 8'(idx);
        loadVal  = val;
        loadReg  = 1'b1;
        @(posedge ck);
        #1 loadReg = 1'b0;
    endtask

    task automatic setMem(input logic [7:0] addr, input logic [7:0] val);
        loadAddr = addr;
        loadVal  = val;
        loadMem  = 1'b1;
        @(posedge ck);
        #1 loadMem = 1'b0;
    endtask

    task automatic applyStimulus(input logic [7:0] r0, input logic [7:0] r1, input logic [7:0] r2);
        rst = 1'b1;
        for (int i = 0; i < 256; i++) imem[i] = 8'hF0;
        setReg(0, r0);
        setReg(1, r1);
        setReg(2, r2);
        setReg(3, 8'h00);
    endtask

    task automatic releaseReset();
        @(posedge ck);
        #1 rst = 1'b0;
    endtask

    task automatic stepCycles(input int n);
        repeat (n) @(negedge ck);
    endtask

    initial begin
        // Reset values and ADD R0,R1 followed by HALT.
        applyStimulus(8'h04, 8'h03, 8'h00);
        imem[0] = 8'h11;
        imem[1] = 8'hF0;
        stepCycles(1);
        checkOutput("rst_pc", pc_out, 8'h00);
        checkOutput("rst_strobes", {5'b0, rf_we, dm_we, dm_re}, 8'h00);
        checkOutput("rst_rf_d", {6'b0, rf_d}, 8'h00);
        checkOutput("rst_rf_wdata", rf_wdata, 8'h00);
        checkOutput("rst_dm_addr", dm_addr, 8'h00);
        checkOutput("rst_dm_wdata", dm_wdata, 8'h00);
        checkOutput("rst_flags", {6'b0, halted, illegal}, 8'h00);
        releaseReset();
        stepCycles(3);
        checkOutput("add_c3_we", rf_we, 1'b0);
        stepCycles(1);
        checkOutput("add_c4_we", rf_we, 1'b1);
        checkOutput("add_c4_rd", rf_d, 2'd0);
        checkOutput("add_c4_wdata", rf_wdata, 8'h07);
        stepCycles(1);
        checkOutput("add_c5_we", rf_we, 1'b0);
        checkOutput("add_c5_pc", pc_out, 8'h01);
        stepCycles(2);
        checkOutput("add_halted", halted, 1'b1);
        checkOutput("add_halt_pc", pc_out, 8'h01);
        checkOutput("add_r0", regs[0], 8'h07);
        stepCycles(3);
        checkOutput("halt_absorb", halted, 1'b1);
        checkOutput("halt_absorb_pc", pc_out, 8'h01);

        // LD R0,[R1] with MEM[2]=07.
        applyStimulus(8'h00, 8'h02, 8'h00);
        setMem(8'h02, 8'h07);
        imem[0] = 8'h51;
        releaseReset();
        stepCycles(3);
        checkOutput("ld_c3_re", dm_re, 1'b0);
        stepCycles(1);
        checkOutput("ld_c4_re", dm_re, 1'b1);
        checkOutput("ld_c4_addr", dm_addr, 8'h02);
        checkOutput("ld_c4_we", rf_we, 1'b0);
        stepCycles(1);
        checkOutput("ld_c5_we", rf_we, 1'b1);
        checkOutput("ld_c5_wdata", rf_wdata, 8'h07);
        checkOutput("ld_c5_re", dm_re, 1'b0);
        stepCycles(1);
        checkOutput("ld_pc", pc_out, 8'h01);

        // LDI R0,A5 then ST R0,[R1] with R1=10.
        applyStimulus(8'h00, 8'h10, 8'h00);
        imem[0] = 8'h70;
        imem[1] = 8'hA5;
        imem[2] = 8'h61;
        releaseReset();
        stepCycles(3);
        checkOutput("ldi_imm_pc", pc_out, 8'h01);
        stepCycles(1);
        checkOutput("ldi_we", rf_we, 1'b1);
        checkOutput("ldi_wdata", rf_wdata, 8'hA5);
        stepCycles(1);
        checkOutput("ldi_next_pc", pc_out, 8'h02);
        stepCycles(2);
        checkOutput("st_exec_we", dm_we, 1'b0);
        stepCycles(1);
        checkOutput("st_mem_we", dm_we, 1'b1);
        checkOutput("st_addr", dm_addr, 8'h10);
        checkOutput("st_wdata", dm_wdata, 8'hA5);
        checkOutput("st_rf_we", rf_we, 1'b0);
        stepCycles(1);
        checkOutput("st_we_drop", dm_we, 1'b0);
        checkOutput("st_pc", pc_out, 8'h03);
        checkOutput("st_mem", dmem[8'h10], 8'hA5);

        // JMP to FF, NOP at FF wraps to 00.
        applyStimulus(8'h00, 8'hFF, 8'h00);
        imem[0]   = 8'h81;
        imem[255] = 8'h00;
        releaseReset();
        stepCycles(3);
        checkOutput("jmp_exec_pc", pc_out, 8'h00);
        stepCycles(1);
        checkOutput("jmp_pc", pc_out, 8'hFF);
        stepCycles(2);
        checkOutput("nop_wrap_pc", pc_out, 8'h00);

        // Undefined opcode C0: executes as NOP and sets sticky illegal.
        applyStimulus(8'h00, 8'h00, 8'h00);
        imem[0] = 8'hC0;
        releaseReset();
        stepCycles(2);
        checkOutput("ill_decode", illegal, 1'b0);
        stepCycles(1);
        checkOutput("ill_set", illegal, 1'b1);
        checkOutput("ill_pc", pc_out, 8'h01);
        stepCycles(2);
        checkOutput("ill_sticky", illegal, 1'b1);
        checkOutput("ill_halt", halted, 1'b1);

        // SUB, AND, OR sequence.
        applyStimulus(8'h0C, 8'h0A, 8'h06);
        imem[0] = 8'h21;
        imem[1] = 8'h36;
        imem[2] = 8'h42;
        releaseReset();
        stepCycles(4);
        checkOutput("sub_wdata", rf_wdata, 8'h02);
        stepCycles(4);
        checkOutput("and_rd", rf_d, 2'd1);
        checkOutput("and_wdata", rf_wdata, 8'h02);
        stepCycles(4);
        checkOutput("or_wdata", rf_wdata, 8'h06);
        checkOutput("or_rd", rf_d, 2'd0);

        // Reset asserted during the WB cycle of ADD aborts the write.
        applyStimulus(8'h04, 8'h03, 8'h00);
        imem[0] = 8'h11;
        releaseReset();
        stepCycles(4);
        checkOutput("abort_pre_we", rf_we, 1'b1);
        rst = 1'b1;
        #1;
        checkOutput("abort_we", rf_we, 1'b0);
        checkOutput("abort_pc", pc_out, 8'h00);
        stepCycles(2);
        checkOutput("abort_r0", regs[0], 8'h04);
        releaseReset();
        stepCycles(4);
        checkOutput("abort_refetch_we", rf_we, 1'b1);
        checkOutput("abort_refetch_wdata", rf_wdata, 8'h07);

        // Opcode 9 with equal operands, then unequal.
        applyStimulus(8'h05, 8'h05, 8'h00);
        imem[0] = 8'h91;
        releaseReset();
`ifdef SEQ_BEQ_EN
        stepCycles(4);
        checkOutput("beq_eq_pc", pc_out, 8'h02);
        checkOutput("beq_eq_ill", illegal, 1'b0);
`else
        stepCycles(3);
        checkOutput("op9_pc", pc_out, 8'h01);
        checkOutput("op9_ill", illegal, 1'b1);
`endif
        applyStimulus(8'h05, 8'h06, 8'h00);
        imem[0] = 8'h91;
        releaseReset();
`ifdef SEQ_BEQ_EN
        stepCycles(4);
        checkOutput("beq_ne_pc", pc_out, 8'h01);
        checkOutput("beq_ne_ill", illegal, 1'b0);
`else
        stepCycles(3);
        checkOutput("op9_ne_pc", pc_out, 8'h01);
        checkOutput("op9_ne_ill", illegal, 1'b1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
